// File: rtl/muldiv_issue_ctrl_if.sv
// Handshake bundle between the ID stage / writeback arbiter and the
// multiply/divide issue controller.
interface muldiv_issue_ctrl_if;
  logic       md_valid_ID;
  logic [2:0] md_op_ID;
  logic [4:0] rd_ID;
  logic [4:0] rs1_ID;
  logic [4:0] rs2_ID;
  logic       rs1use_ID;
  logic       rs2use_ID;
  logic       flush_ID;
  logic       wb_ready;

  logic       unit_start;
  logic [2:0] unit_op;
  logic       md_stall;
  logic       busy;
  logic [4:0] busy_rd;
  logic       md_wb_en;
  logic [4:0] md_wb_rd;

  modport slave (
    input  md_valid_ID, md_op_ID, rd_ID, rs1_ID, rs2_ID,
           rs1use_ID, rs2use_ID, flush_ID, wb_ready,
    output unit_start, unit_op, md_stall, busy, busy_rd, md_wb_en, md_wb_rd
  );

  modport master (
    output md_valid_ID, md_op_ID, rd_ID, rs1_ID, rs2_ID,
           rs1use_ID, rs2use_ID, flush_ID, wb_ready,
    input  unit_start, unit_op, md_stall, busy, busy_rd, md_wb_en, md_wb_rd
  );
endinterface

// File: rtl/muldiv_issue_ctrl.sv
// Issue controller for the shared iterative mul/div unit: starts operations,
// counts their fixed latency, raises stalls and owns the RF write port when done.
module muldiv_issue_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 33
) (
  input  logic                  clk,
  input  logic                  rst_n,
  muldiv_issue_ctrl_if.slave    md
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [5:0] MUL_CNT0 = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_CNT0 = 6'(DIV_LAT - 1);

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic [4:0] rd_q, rd_d;

  logic busy;
  logic done;
  logic dep_hit;
  logic port_free;
  logic issue;

  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    dep_hit   = busy && (rd_q != 5'd0) &&
                ((md.rs1use_ID && (md.rs1_ID == rd_q)) ||
                 (md.rs2use_ID && (md.rs2_ID == rd_q)));
    // The unit can accept a new op when idle, or when the finished result
    // leaves through the write port in this very cycle.
    port_free = (state_q == IDLE) || (done && md.wb_ready);
    // rst_n gating keeps every output at 0 while reset is held.
    issue     = rst_n && md.md_valid_ID && !md.flush_ID && port_free && !dep_hit;
  end

  assign md.unit_start = issue;
  assign md.unit_op    = op_q;
  assign md.md_stall   = rst_n && !md.flush_ID &&
                         ((md.md_valid_ID && !issue) || dep_hit);
  assign md.busy       = busy;
  assign md.busy_rd    = busy ? rd_q : 5'd0;
  assign md.md_wb_en   = done && md.wb_ready;
  assign md.md_wb_rd   = done ? rd_q : 5'd0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;

    unique case (state_q)
      IDLE: ;
      RUN: begin
        if (cnt_q == 6'd1) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      DONE: begin
        if (md.wb_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new issue overrides the retire path above (back-to-back from DONE).
    if (issue) begin
      state_d = RUN;
      op_d    = md.md_op_ID;
      rd_d    = md.rd_ID;
      cnt_d   = md.md_op_ID[2] ? DIV_CNT0 : MUL_CNT0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      op_q    <= 3'd0;
      rd_q    <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
    end
  end

endmodule

// File: doc/muldiv_issue_ctrl.md
# muldiv_issue_ctrl

Issue controller for the shared iterative multiply/divide unit in the five-stage RV32 pipeline. It accepts M-extension instructions from ID, starts the unit, and counts its fixed latency. It raises stall requests to the hazard detection unit for structural and RAW conflicts, and arbitrates the single register-file write port against the normal MEM/WB writeback.

## Interface
- MUL_LAT, 4: multiply latency in cycles, start to result; legal range 2..63.
- DIV_LAT, 33: divide/remainder latency in cycles; legal range 2..63.
- clk  in  1  pipeline clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- md_valid_ID  in  1  ID holds an M-extension instruction.
- md_op_ID  in  3  funct3; 0xx = multiply class, 1xx = divide class.
- rd_ID, rs1_ID, rs2_ID  in  5 each  register fields of the ID instruction (any type).
- rs1use_ID, rs2use_ID  in  1 each  ID instruction reads rs1/rs2.
- flush_ID  in  1  ID instruction is being killed this cycle (branch taken).
- wb_ready  in  1  normal writeback does not use the register-file write port this cycle.
- unit_start  out  1  single-cycle start pulse to the unit.
- unit_op  out  3  latched funct3, valid while busy.
- md_stall  out  1  stall request to hazard unit: freeze PC/IF-ID, bubble ID-EX.
- busy  out  1  operation in flight (RUN or DONE).
- busy_rd  out  5  destination of the in-flight operation; 0 when idle.
- md_wb_en  out  1  controller owns the write port this cycle; write unit result to md_wb_rd.
- md_wb_rd  out  5  writeback destination.

## Operation
- States: IDLE, RUN, DONE. 6-bit down-counter cnt. Registers op_q[2:0] and rd_q[4:0].
- issue = md_valid_ID & !flush_ID & (IDLE | (DONE & wb_ready)) & !dep_hit.
- dep_hit = busy & rd_q!=0 & ((rs1use_ID & rs1_ID==rd_q) | (rs2use_ID & rs2_ID==rd_q)). It applies to every ID instruction, M-type or not.
- unit_start = issue (combinational). unit_op = op_q.
- On an issue edge: op_q<=md_op_ID, rd_q<=rd_ID, cnt<=(md_op_ID[2] ? DIV_LAT : MUL_LAT)-1, state<=RUN.
- RUN: if cnt==1 then state<=DONE, else cnt<=cnt-1.
- DONE: md_wb_en=wb_ready, md_wb_rd=rd_q. If wb_ready and no issue, state<=IDLE. If wb_ready and issue, go back to RUN with the new op (back-to-back). If !wb_ready, hold DONE; the result waits for the port.
- md_stall = !flush_ID & ((md_valid_ID & !issue) | dep_hit).
- busy = state!=IDLE. busy_rd = busy ? rd_q : 0.
- rd_ID==0: the operation still runs for its full latency. md_wb_en is still asserted; the register file ignores x0.
- flush_ID kills only the ID request: no start, no stall. An in-flight operation is older than the branch and is never aborted by flush_ID.
- dep_hit also holds in DONE&wb_ready, even though the result is written that cycle. There is no forwarding; the dependent issues or proceeds one cycle later.

## Timing
- Reset (async, rst_n=0): state=IDLE, cnt=0, op_q=0, rd_q=0. All outputs 0: unit_start, unit_op, md_stall, busy, busy_rd, md_wb_en, md_wb_rd.
- Reset asserted mid-RUN or DONE: immediately IDLE with all outputs 0. The pending result is discarded.
- Issue in cycle T: unit_start=1 in T. busy=1 from T+1. DONE is entered at T+LAT. md_wb_en is first possible in T+LAT.
- A stalled M request issues in the first cycle its issue condition is true. md_stall drops in that same cycle.
- Counter never underflows: RUN exits at cnt==1, and LAT>=2 is guaranteed by parameter range.

## Test plan
- MUL x5,x1,x2 issued at cycle 10, wb_ready=1 -> unit_start at 10; busy 11..14; md_wb_en=1, md_wb_rd=5 at 14; IDLE at 15.
- DIV issued at 0 with DIV_LAT=33, then a second MUL in ID at cycle 1 -> md_stall=1 in cycles 1..32; MUL issues at 33 (back-to-back) with md_wb_en=1 for the DIV in the same cycle.
- MUL x7 in flight, then ADD x8,x7,x3 in ID -> md_stall=1 until the cycle after md_wb_en for rd 7; no stall for ADD x8,x4,x3.
- Result in DONE with wb_ready=0 for 3 cycles -> DONE held, md_wb_en=0 for 3 cycles, then 1 for exactly one cycle; busy_rd stays at rd until written.
- md_valid_ID=1 and flush_ID=1 in IDLE -> no unit_start, md_stall=0, state stays IDLE.
- rst_n pulled low at cycle 5 of a DIV -> all outputs 0 immediately; after release, a new MUL issues normally with full MUL_LAT.
